// File: rtl/galivan_pkg.sv
// Shared constants for the Galivan ROM loader and the core's ROM mux:
// ioctl indices, the ROM region map and the loader state type.
package galivan_pkg;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_DIP = 8'd254;

    localparam int NUM_REG = 4;

    // Region order: 0 main CPU, 1 sound, 2 tiles, 3 sprites (inclusive bounds)
    localparam logic [NUM_REG-1:0][26:0] REG_BASE = {27'h40000, 27'h20000, 27'h14000, 27'h00000};
    localparam logic [NUM_REG-1:0][26:0] REG_END  = {27'h4FFFF, 27'h3FFFF, 27'h1FFFF, 27'h13FFF};

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI
    } loader_state_t;

endpackage

// File: rtl/galivan_rom_map.sv
// Combinational ioctl byte address -> {hit, one-hot region, region-relative address}.
// Also used by the core's ROM mux, so it carries no state.
module galivan_rom_map
    import galivan_pkg::*;
#(
    parameter int NREG    = NUM_REG,
    parameter int RADDR_W = 17
) (
    input  logic [26:0]        addr,
    output logic               hit,
    output logic [NREG-1:0]    region,
    output logic [RADDR_W-1:0] rel_addr
);

    logic [26:0] offs;

    always_comb begin
        hit      = 1'b0;
        region   = '0;
        rel_addr = '0;
        offs     = '0;
        for (int r = 0; r < NREG; r++) begin
            // Unsigned wrap makes addresses below the base fail the size test
            offs = addr - REG_BASE[r];
            if (offs <= (REG_END[r] - REG_BASE[r])) begin
                hit       = 1'b1;
                region[r] = 1'b1;
                rel_addr  = offs[RADDR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/galivan_rom_loader.sv
// Turns the hps_io ioctl word stream into region-steered ROM byte writes and DIP
// register updates, and sequences rom_init / core_reset around the download.
module galivan_rom_loader
    import galivan_pkg::*;
#(
    parameter int RADDR_W  = 17,
    parameter int NREG     = NUM_REG,
    parameter int RST_HOLD = 255
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               ioctl_download,
    input  logic [7:0]         ioctl_index,
    input  logic               ioctl_wr,
    input  logic [26:0]        ioctl_addr,
    input  logic [15:0]        ioctl_dout,
    output logic               ioctl_wait,
    output logic               rom_init,
    output logic               core_reset,
    output logic [NREG-1:0]    rom_we,
    output logic [RADDR_W-1:0] rom_addr,
    output logic [7:0]         rom_data,
    output logic [15:0]        dsw,
    output logic               load_err
);

    localparam int HOLD_W = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

    loader_state_t      state_q, state_d;
    logic [NREG-1:0]    reg_q, reg_d;
    logic [RADDR_W-1:0] hi_addr_q, hi_addr_d;
    logic [7:0]         hi_data_q, hi_data_d;
    logic [NREG-1:0]    rom_we_q, rom_we_d;
    logic [RADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]         rom_data_q, rom_data_d;
    logic               rom_init_q, rom_init_d;
    logic               load_err_q, load_err_d;
    logic               dl_rom_q, dl_rom_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [15:0]        dsw_q, dsw_d;

    logic               map_hit;
    logic [NREG-1:0]    map_region;
    logic [RADDR_W-1:0] map_rel;
    logic               wr_rom;
    logic               wr_dip;
    logic               err_set;

    galivan_rom_map #(
        .NREG    (NREG),
        .RADDR_W (RADDR_W)
    ) u_map (
        .addr     (ioctl_addr),
        .hit      (map_hit),
        .region   (map_region),
        .rel_addr (map_rel)
    );

    assign dl_rom_d = ioctl_download && (ioctl_index == IDX_ROM);
    assign wr_rom   = ioctl_wr && (ioctl_index == IDX_ROM);
    assign wr_dip   = ioctl_wr && (ioctl_index == IDX_DIP) && (ioctl_addr[24:3] == '0)
                      && (ioctl_addr[2:1] == 2'b00);

    always_comb begin
        state_d    = state_q;
        reg_d      = reg_q;
        hi_addr_d  = hi_addr_q;
        hi_data_d  = hi_data_q;
        rom_we_d   = '0;
        rom_addr_d = rom_addr_q;
        rom_data_d = rom_data_q;
        err_set    = 1'b0;

        case (state_q)
            IDLE: begin
                if (wr_rom) begin
                    if (ioctl_addr[0] || !map_hit) begin
                        err_set = 1'b1;
                    end else begin
                        // Region is decoded once; the high byte reuses it
                        state_d    = LO;
                        reg_d      = map_region;
                        hi_addr_d  = map_rel + RADDR_W'(1);
                        hi_data_d  = ioctl_dout[15:8];
                        rom_we_d   = map_region;
                        rom_addr_d = map_rel;
                        rom_data_d = ioctl_dout[7:0];
                    end
                end
            end
            LO: begin
                state_d    = HI;
                rom_we_d   = reg_q;
                rom_addr_d = hi_addr_q;
                rom_data_d = hi_data_q;
            end
            HI:      state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (ioctl_wr && (state_q != IDLE)) begin
            err_set = 1'b1;
        end

        load_err_d = load_err_q;
        if (dl_rom_d && !dl_rom_q) begin
            load_err_d = 1'b0;
        end
        if (err_set) begin
            load_err_d = 1'b1;
        end

        // Looking at the next state keeps rom_init high through a write that
        // coincides with the end of the download
        rom_init_d = dl_rom_d || (state_d != IDLE);

        hold_d = hold_q;
        if (rom_init_q) begin
            hold_d = HOLD_W'(RST_HOLD);
        end else if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
        end

        dsw_d = wr_dip ? ioctl_dout : dsw_q;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= IDLE;
            reg_q      <= '0;
            hi_addr_q  <= '0;
            hi_data_q  <= '0;
            rom_we_q   <= '0;
            rom_addr_q <= '0;
            rom_data_q <= '0;
            rom_init_q <= 1'b0;
            load_err_q <= 1'b0;
            dl_rom_q   <= 1'b0;
            hold_q     <= HOLD_W'(RST_HOLD);
        end else begin
            state_q    <= state_d;
            reg_q      <= reg_d;
            hi_addr_q  <= hi_addr_d;
            hi_data_q  <= hi_data_d;
            rom_we_q   <= rom_we_d;
            rom_addr_q <= rom_addr_d;
            rom_data_q <= rom_data_d;
            rom_init_q <= rom_init_d;
            load_err_q <= load_err_d;
            dl_rom_q   <= dl_rom_d;
            hold_q     <= hold_d;
        end
    end

    // DIP settings survive an OSD reset; power-up zero comes from FPGA configuration
    always_ff @(posedge clk_sys) begin
        dsw_q <= dsw_d;
    end

    assign ioctl_wait = (state_q != IDLE);
    assign rom_init   = rom_init_q;
    assign core_reset = reset || rom_init_q || (hold_q != '0);
    assign rom_we     = rom_we_q;
    assign rom_addr   = rom_addr_q;
    assign rom_data   = rom_data_q;
    assign dsw        = dsw_q;
    assign load_err   = load_err_q;

endmodule
